instr_seq_ctrl: RTL and testbench
=================================

INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-004 SHALL have: imem_req  out  1 / imem_addr  out  8 / imem_ack  in  1 / imem_rdata  in  32  instruction fetch handshake.
REQ-005 SHALL have: dmem_rd  out  1 / dmem_wr  out  1 / dmem_ack  in  1  data-memory strobes.
REQ-006 SHALL have: instr_q  out  32  latched instruction feeding the immediate generator and decoders.
REQ-007 SHALL have: alu_en  out  1 / reg_we  out  1 / pc  out  8 / busy  out  1 / trap  out  1.
REQ-008 SHALL have parameter: PC_RESET, default 8'h00, pc value after reset.

Function
REQ-009 SHALL implement the FSM IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs registered or decoded from state only.
REQ-010 SHALL move IDLE->FETCH when run=1.
REQ-011 SHALL hold imem_req=1 and imem_addr=pc in FETCH until imem_ack=1, then latch imem_rdata into instr_q and enter DECODE; the minimum is 1 cycle per state.
REQ-012 SHALL classify the instruction in DECODE from instr_q[6:5] and instr_q[4]: 00/0 = ALU-immediate, 00/1 = load, 01 = store, 10 or 11 = unsupported.
REQ-013 SHALL assert alu_en for exactly one cycle in EXEC for every supported class.
REQ-014 SHALL route ALU-immediate EXEC->WB; load EXEC->MEM(dmem_rd)->WB; store EXEC->MEM(dmem_wr)->FETCH/IDLE with no WB.
REQ-015 SHALL hold dmem_rd or dmem_wr in MEM until dmem_ack=1, and never assert both.
REQ-016 SHALL assert reg_we for exactly one cycle in WB.
REQ-017 SHALL increment pc by 1 modulo 256 on the last cycle of each instruction (leaving WB, or leaving MEM for store); 8'hFF wraps to 8'h00.
REQ-018 SHALL, at instruction end, go to FETCH if run=1, else IDLE; run falling mid-instruction SHALL NOT abort it.
REQ-019 SHALL drive busy=1 in every state except IDLE and TRAP.
REQ-020 SHALL ignore imem_ack outside FETCH and dmem_ack outside MEM.
REQ-021 SHALL keep instr_q stable from DECODE until the next FETCH handshake.

Reset
REQ-022 SHALL on rst_n=0 immediately enter IDLE with pc=PC_RESET, instr_q=0, and imem_req, dmem_rd, dmem_wr, alu_en, reg_we, busy and trap all 0.
REQ-023 SHALL, when reset is asserted mid-handshake, drop the strobe without waiting for an ack; a late ack after reset SHALL be ignored.

Configuration
REQ-024 SHALL, with SEQ_TRAP_EN defined, move an unsupported class from DECODE to TRAP, hold trap=1 and pc unchanged, and stay there until reset.
REQ-025 SHALL, without SEQ_TRAP_EN, treat an unsupported class as a NOP: DECODE->FETCH/IDLE, pc+1, no alu_en/reg_we/dmem strobe, and trap tied 0.

Structure
REQ-026 SHALL place the state enum, the instruction-class enum and the opcode field positions ([6:5], [4]) in shared package cpu_ctrl_pkg.
REQ-027 SHALL be a single module; the classification logic MAY be split into sub-module instr_class_dec.

Verification
REQ-028 SHALL cover: reset, run=1, ALU-imm 32'h0000_0000 with 0-cycle ack -> FETCH,DECODE,EXEC,WB; alu_en then reg_we one cycle each; pc 00->01.
REQ-029 SHALL cover: load 32'h0000_0010 with dmem_ack delayed 3 cycles -> dmem_rd held 4 cycles, reg_we once, pc+1.
REQ-030 SHALL cover: store 32'h0000_0020 -> dmem_wr until ack, reg_we never asserted, pc+1.
REQ-031 SHALL cover: pc=8'hFF completing an instruction -> pc=8'h00.
REQ-032 SHALL cover: instr 32'h0000_0040, with SEQ_TRAP_EN -> trap=1 and busy=0, pc frozen; without it -> NOP with pc+1 and trap=0.
REQ-033 SHALL cover: run dropped during MEM -> instruction completes, then IDLE; rst_n pulsed during FETCH -> imem_req=0 same cycle, and pc=PC_RESET.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the instruction sequencer: FSM states, instruction classes and opcode field positions.
// Pure declarations, no logic, no latency, no flow control.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_ALU_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_UNSUP
  } instr_class_e;

  // instr[6:5] selects the major class, instr[4] splits ALU-immediate from load
  localparam int OPC_MAJ_HI = 6;
  localparam int OPC_MAJ_LO = 5;
  localparam int OPC_LD_BIT = 4;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier over instr[6:4] (bit order {maj[1:0], ld}).
// Zero latency, no flow control.
module instr_class_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0]   op_i,
  output instr_class_e cls_o
);

  always_comb begin
    cls_o = CLS_UNSUP;
    unique case (op_i[2:1])
      2'b00:   cls_o = op_i[0] ? CLS_LOAD : CLS_ALU_IMM;
      2'b01:   cls_o = CLS_STORE;
      default: cls_o = CLS_UNSUP;
    endcase
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; all strobes registered, imem/dmem held until ack.
// Optional SEQ_TRAP_EN: unsupported class parks in TRAP until reset, otherwise it retires as a NOP.
module instr_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic        dmem_ack,
  output logic [31:0] instr_q,
  output logic        alu_en,
  output logic        reg_we,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        trap
);

  seq_state_e   state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [31:0]  instr_d;
  instr_class_e cls;

  instr_class_dec u_dec (
    .op_i  (instr_q[OPC_MAJ_HI:OPC_LD_BIT]),
    .cls_o (cls)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == CLS_UNSUP) begin
`ifdef SEQ_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = run ? S_FETCH : S_IDLE;
          pc_d    = pc_q + 8'd1;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = (cls == CLS_ALU_IMM) ? S_WB : S_MEM;
      S_MEM: begin
        if (dmem_ack) begin
          if (cls == CLS_STORE) begin
            state_d = run ? S_FETCH : S_IDLE;
            pc_d    = pc_q + 8'd1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = run ? S_FETCH : S_IDLE;
        pc_d    = pc_q + 8'd1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the decode of state_d, so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_RESET;
      instr_q  <= 32'h0;
      imem_req <= 1'b0;
      dmem_rd  <= 1'b0;
      dmem_wr  <= 1'b0;
      alu_en   <= 1'b0;
      reg_we   <= 1'b0;
      busy     <= 1'b0;
      trap     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      imem_req <= (state_d == S_FETCH);
      dmem_rd  <= (state_d == S_MEM) && (cls == CLS_LOAD);
      dmem_wr  <= (state_d == S_MEM) && (cls == CLS_STORE);
      alu_en   <= (state_d == S_EXEC);
      reg_we   <= (state_d == S_WB);
      busy     <= (state_d != S_IDLE) && (state_d != S_TRAP);
      trap     <= (state_d == S_TRAP);
    end
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: memory responders, strobe counters and hand-computed expectations.
// Build with or without SEQ_TRAP_EN; the unsupported-class expectations follow the macro.
module tb_instr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_rdata, instr_q;
  logic        dmem_rd, dmem_wr, dmem_ack;
  logic        alu_en, reg_we, busy, trap;

  always #5 clk = ~clk;

  instr_seq_ctrl #(.PC_RESET(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_rd    (dmem_rd),
    .dmem_wr    (dmem_wr),
    .dmem_ack   (dmem_ack),
    .instr_q    (instr_q),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .pc         (pc),
    .busy       (busy),
    .trap       (trap)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] instr_word = 32'h0;
  int          dmem_delay = 0;
  logic        imem_hold  = 1'b0;
  logic        late_ack   = 1'b0;
  int cyc = 0, mem_cnt = 0;
  int n_alu = 0, n_we = 0, n_rd = 0, n_wr = 0, n_both = 0, n_busy = 0;
  int alu_cyc = 0, we_cyc = 0;
  logic [7:0] fetch_addr = 8'h0;
  logic [7:0] exp_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory responders and strobe monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    imem_ack   = (imem_req && !imem_hold) || late_ack;
    imem_rdata = instr_word;
    if (imem_req) fetch_addr = imem_addr;
    if (dmem_rd || dmem_wr) begin
      dmem_ack = (mem_cnt == dmem_delay);
      mem_cnt++;
    end else begin
      dmem_ack = 1'b0;
      mem_cnt  = 0;
    end
    if (alu_en) begin n_alu++; alu_cyc = cyc; end
    if (reg_we) begin n_we++;  we_cyc  = cyc; end
    if (dmem_rd) n_rd++;
    if (dmem_wr) n_wr++;
    if (dmem_rd && dmem_wr) n_both++;
    if (busy) n_busy++;
  end

  task automatic clr();
    n_alu = 0; n_we = 0; n_rd = 0; n_wr = 0; n_busy = 0;
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string tag);
    for (int i = 0; i < max && busy !== lvl; i++) @(negedge clk);
    check_eq(tag, busy, lvl);
  endtask

  task automatic go(input logic [31:0] w, input int dly);
    instr_word = w;
    dmem_delay = dly;
    clr();
    run = 1'b1;
    wait_busy(1'b1, 10, "start");
    run = 1'b0;
    wait_busy(1'b0, 40, "done");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_pc", pc, 8'h00);
    check_eq("rst_trap", trap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_pc", pc, 8'h00);
    check_eq("reset_instr", instr_q, 32'h0);
    check_eq("reset_strobes", {imem_req, dmem_rd, dmem_wr, alu_en, reg_we, busy, trap}, 7'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU-immediate with zero-wait fetch
    go(32'h0000_0000, 0);
    check_eq("alu_fetch_addr", fetch_addr, 8'h00);
    check_eq("alu_alu_en", n_alu, 1);
    check_eq("alu_reg_we", n_we, 1);
    check_eq("alu_we_after_alu", we_cyc - alu_cyc, 1);
    check_eq("alu_dmem", n_rd + n_wr, 0);
    check_eq("alu_busy_cycles", n_busy, 4);
    check_eq("alu_pc", pc, 8'h01);

    // Load with ack on the fourth MEM cycle
    go(32'h0000_0010, 3);
    check_eq("ld_instr_q", instr_q, 32'h0000_0010);
    check_eq("ld_rd_cycles", n_rd, 4);
    check_eq("ld_wr", n_wr, 0);
    check_eq("ld_reg_we", n_we, 1);
    check_eq("ld_alu_en", n_alu, 1);
    check_eq("ld_busy_cycles", n_busy, 8);
    check_eq("ld_pc", pc, 8'h02);

    // Store skips WB
    go(32'h0000_0020, 1);
    check_eq("st_wr_cycles", n_wr, 2);
    check_eq("st_rd", n_rd, 0);
    check_eq("st_reg_we", n_we, 0);
    check_eq("st_busy_cycles", n_busy, 5);
    check_eq("st_pc", pc, 8'h03);

    // run dropped while in MEM
    instr_word = 32'h0000_0010; dmem_delay = 2; clr();
    run = 1'b1;
    for (int i = 0; i < 20 && !dmem_rd; i++) @(negedge clk);
    check_eq("rd_seen", dmem_rd, 1'b1);
    run = 1'b0;
    wait_busy(1'b0, 20, "rd_done");
    check_eq("rundrop_rd_cycles", n_rd, 3);
    check_eq("rundrop_reg_we", n_we, 1);
    check_eq("rundrop_pc", pc, 8'h04);
    repeat (3) @(negedge clk);
    check_eq("rundrop_idle_busy", busy, 1'b0);
    check_eq("rundrop_idle_pc", pc, 8'h04);

    // Unsupported class
    go(32'h0000_0040, 0);
    check_eq("unsup_alu_en", n_alu, 0);
    check_eq("unsup_reg_we", n_we, 0);
    check_eq("unsup_dmem", n_rd + n_wr, 0);
`ifdef SEQ_TRAP_EN
    check_eq("trap_flag", trap, 1'b1);
    check_eq("trap_pc", pc, 8'h04);
    run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    check_eq("trap_held", {trap, busy}, 2'b10);
    check_eq("trap_pc_held", pc, 8'h04);
    pulse_reset();
    go(32'h0000_0000, 0);
    exp_pc = 8'h01;
`else
    check_eq("nop_trap", trap, 1'b0);
    check_eq("nop_pc", pc, 8'h05);
    check_eq("nop_busy_cycles", n_busy, 2);
    exp_pc = 8'h05;
`endif
    check_eq("pre_rst_pc", pc, exp_pc);

    // Reset in the middle of a stalled fetch, then a stray ack
    imem_hold = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    check_eq("fetch_req", imem_req, 1'b1);
    check_eq("fetch_addr", imem_addr, exp_pc);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_fetch_req", imem_req, 1'b0);
    check_eq("rst_fetch_pc", pc, 8'h00);
    check_eq("rst_fetch_busy", busy, 1'b0);
    check_eq("rst_fetch_instr", instr_q, 32'h0);
    run = 1'b0; imem_hold = 1'b0; late_ack = 1'b1; instr_word = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 late_ack = 1'b0;
    check_eq("late_ack_busy", busy, 1'b0);
    check_eq("late_ack_instr", instr_q, 32'h0);
    check_eq("late_ack_pc", pc, 8'h00);

    // pc wrap: 256 back-to-back ALU instructions
    @(negedge clk);
    instr_word = 32'h0; dmem_delay = 0; clr();
    run = 1'b1;
    for (int i = 0; i < 2000 && pc !== 8'hFF; i++) @(negedge clk);
    check_eq("wrap_reach_ff", pc, 8'hFF);
    run = 1'b0;
    wait_busy(1'b0, 20, "wrap_done");
    check_eq("wrap_pc", pc, 8'h00);
    check_eq("wrap_reg_we", n_we, 256);
    check_eq("never_both_strobes", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
